stage_one_fetch: RTL
====================

// Module: stage_one_fetch
// PURPOSE
//  Instruction-fetch stage (stage one) of the MUSA core. It consumes the redirect controls that
//  decode produces (pc_src, push, pop, PCWrite, 26-bit jump index) and supplies decode with the
//  instruction word it expects. Holds the PC, runs the instruction-memory request handshake and
//  keeps a return-address stack (RAS) for call/return.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  RAS_DEPTH  8              return-address stack entries (power of two)
//  RAS_PTR_W  3              log2(RAS_DEPTH)
// PORTS
//  clk            in   1   core clock, all state on rising edge
//  rst            in   1   asynchronous reset, active-low (0 = reset)
//  PCWrite        in   1   decode accepts current instruction; advance PC
//  pcSrc          in   3   next-PC select (encoding below)
//  push           in   1   push PC+4 onto RAS (call)
//  pop            in   1   discard RAS top (return)
//  out_jump       in   26  jump index from decode (instruction[25:0])
//  branch_offset  in   16  branch word offset (instruction[15:0])
//  jump_reg       in   32  register target (readData1)
//  imem_ready     in   1   instruction memory data valid this cycle
//  imem_data      in   32  instruction memory read data
//  imem_req       out  1   fetch request
//  imem_addr      out  32  fetch address (= pc)
//  instruction    out  32  instruction word presented to decode
//  instr_valid    out  1   instruction holds a fetched word
//  pc_plus4       out  32  pc + 4 of the presented instruction
//  ras_overflow   out  1   one-cycle pulse: push while RAS full
//  ras_underflow  out  1   one-cycle pulse: pop or return while RAS empty
// BEHAVIOUR
//  Reset (rst=0, async):
//   pc=RESET_PC, state=REQ, instruction=32'h0, instr_valid=0, RAS count/pointer=0, flags=0.
//   imem_req is 1 from the first cycle after reset release.
//  FSM:
//   REQ:   imem_req=1, imem_addr=pc. On imem_ready: instruction<=imem_data, instr_valid<=1, go ISSUE.
//   ISSUE: imem_req=0. instruction and instr_valid hold.
//          PCWrite=0 -> stay (stall); push/pop ignored.
//          PCWrite=1 -> pc<=next_pc, RAS update, instr_valid<=0, go REQ.
//   Fetch latency: >=1 cycle REQ plus 1 cycle ISSUE, so at most one instruction per 2 cycles.
//   imem_ready outside REQ is ignored.
//  next_pc (32-bit, modulo 2^32, wraps silently):
//   000  pc+4
//   001  pc+4 + {{14{off[15]}}, off, 2'b00}
//   010  {pc_plus4[31:28], out_jump, 2'b00}
//   011  jump_reg
//   100  RAS top; if RAS empty, pc+4 and ras_underflow pulse
//   101-111  pc+4
//  RAS (acts only on an ISSUE cycle with PCWrite=1):
//   push only: stack[ptr]<=pc+4, ptr++ (wraps), count saturates at RAS_DEPTH.
//   push when full: oldest entry overwritten, ras_overflow pulse.
//   pop only: ptr--, count--. pop when empty: no change, ras_underflow pulse.
//   push+pop together: top entry replaced by pc+4; count unchanged.
//   push+pop when empty: acts as a plain push, with an underflow pulse.
//   pcSrc=100 without pop: uses top as target (peek) and leaves the stack unchanged.
//   pcSrc=100 with pop: target is the pre-pop top.
//   Only one underflow pulse per cycle, even if both the pop and pcSrc=100 underflow.
//  pc_plus4 is combinational pc+4 and is stable throughout ISSUE.
//  Reset mid-fetch: state returns to REQ and the in-flight imem response is dropped.
// TESTING
//  1 Reset, imem_ready 2 cycles after req with data 32'h2002_0005
//    -> instruction=32'h2002_0005, instr_valid=1, imem_addr=0, then pc_plus4=4.
//  2 ISSUE at pc=0x100, PCWrite=0 for 3 cycles, then PCWrite=1, pcSrc=001, offset=16'hFFFE
//    -> PC held for the 3 stall cycles; next imem_addr=0x0FC.
//  3 pc=0x1000_0040, pcSrc=010, out_jump=26'h000_0010 -> imem_addr=0x1000_0040.
//    pc=0xFFFF_FFFC, pcSrc=000 -> imem_addr=0x0000_0000 (wrap).
//  4 Call at pc=0x200 (pcSrc=010, push=1), then return (pcSrc=100, pop=1)
//    -> return fetch at 0x204; RAS count back to 0.
//  5 Nine pushes with RAS_DEPTH=8 -> ras_overflow pulses on the 9th push.
//    Eight returns yield push addresses 9..2 in LIFO order; a ninth return -> underflow pulse, pc+4.
//  6 Assert rst=0 during REQ while imem_ready=1
//    -> after release pc=RESET_PC, instr_valid=0, and the stale data is not latched.

Source files
------------

// File: rtl/stage_one_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stage_one_fetch                                                 |
// | Function : MUSA instruction fetch: PC, imem request handshake, RAS         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module stage_one_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 8,
  parameter int          RAS_PTR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic [2:0]  pcSrc,
  input  logic        push,
  input  logic        pop,
  input  logic [25:0] out_jump,
  input  logic [15:0] branch_offset,
  input  logic [31:0] jump_reg,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc_plus4,
  output logic        ras_overflow,
  output logic        ras_underflow
);

  localparam logic [0:0]           c_ST_REQ   = 1'b0;
  localparam logic [0:0]           c_ST_ISSUE = 1'b1;
  localparam logic [RAS_PTR_W:0]   c_FULL     = (RAS_PTR_W+1)'(RAS_DEPTH);
  localparam logic [RAS_PTR_W:0]   c_CNT_ONE  = (RAS_PTR_W+1)'(1);
  localparam logic [RAS_PTR_W-1:0] c_PTR_ONE  = RAS_PTR_W'(1);

  logic [0:0]           r_state;
  logic [0:0]           w_state_next;
  logic [31:0]          r_pc;
  logic [31:0]          r_instruction;
  logic                 r_instr_valid;
  logic [31:0]          r_ras [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] r_ras_ptr;
  logic [RAS_PTR_W:0]   r_ras_count;
  logic                 r_ras_overflow;
  logic                 r_ras_underflow;

  logic [31:0]          w_pc_plus4;
  logic [31:0]          w_branch_target;
  logic [31:0]          w_next_pc;
  logic [31:0]          w_ras_top;
  logic [RAS_PTR_W-1:0] w_top_ptr;
  logic [RAS_PTR_W-1:0] w_wr_ptr;
  logic                 w_fire;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_replace;
  logic                 w_underflow;

  assign w_fire          = (r_state == c_ST_ISSUE) && PCWrite;
  assign w_empty         = (r_ras_count == '0);
  assign w_full          = (r_ras_count == c_FULL);
  assign w_top_ptr       = r_ras_ptr - c_PTR_ONE;
  assign w_ras_top       = r_ras[w_top_ptr];
  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_branch_target = w_pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  // push+pop on a non-empty stack rewrites the top in place
  assign w_replace       = push && pop && !w_empty;
  assign w_wr_ptr        = w_replace ? w_top_ptr : r_ras_ptr;
  assign w_underflow     = w_empty && (pop || (pcSrc == 3'b100));

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (pcSrc)
      3'b001:  w_next_pc = w_branch_target;
      3'b010:  w_next_pc = {w_pc_plus4[31:28], out_jump, 2'b00};
      3'b011:  w_next_pc = jump_reg;
      3'b100:  w_next_pc = w_empty ? w_pc_plus4 : w_ras_top;
      default: w_next_pc = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_ST_REQ;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_REQ:   if (imem_ready) w_state_next = c_ST_ISSUE;
      c_ST_ISSUE: if (PCWrite)    w_state_next = c_ST_REQ;
      default:    w_state_next = c_ST_REQ;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    case (r_state)
      c_ST_REQ: imem_req = 1'b1;
      default:  imem_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_instruction <= 32'h0;
      r_instr_valid <= 1'b0;
    end else begin
      if ((r_state == c_ST_REQ) && imem_ready) begin
        r_instruction <= imem_data;
        r_instr_valid <= 1'b1;
      end else if (w_fire) begin
        r_pc          <= w_next_pc;
        r_instr_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ras_ptr       <= '0;
      r_ras_count     <= '0;
      r_ras_overflow  <= 1'b0;
      r_ras_underflow <= 1'b0;
    end else begin
      r_ras_overflow  <= w_fire && push && !w_replace && w_full;
      r_ras_underflow <= w_fire && w_underflow;
      if (w_fire) begin
        if (push && !w_replace) begin
          r_ras_ptr <= r_ras_ptr + c_PTR_ONE;
          if (!w_full) r_ras_count <= r_ras_count + c_CNT_ONE;
        end else if (pop && !push && !w_empty) begin
          r_ras_ptr   <= w_top_ptr;
          r_ras_count <= r_ras_count - c_CNT_ONE;
        end
      end
    end
  end

  // Stack storage needs no reset: the count guards every read
  always_ff @(posedge clk) begin
    if (w_fire && push) r_ras[w_wr_ptr] <= w_pc_plus4;
  end

  assign imem_addr     = r_pc;
  assign instruction   = r_instruction;
  assign instr_valid   = r_instr_valid;
  assign pc_plus4      = w_pc_plus4;
  assign ras_overflow  = r_ras_overflow;
  assign ras_underflow = r_ras_underflow;

endmodule
`default_nettype wire
